br_lite_ni: RTL and testbench

BR_LITE_NI -- requirements
Module: br_lite_ni

---
 rtl/br_lite_ni_pkg.sv | 33 +++
 rtl/br_lite_ni_fifo.sv | 67 ++++++
 rtl/br_lite_ni.sv | 187 ++++++++++++++++++
 tb/tb_br_lite_ni.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/br_lite_ni_pkg.sv
`default_nettype none
// ============================================================================
// Package     : BrLitePkg
// Description : Shared types for the BR-lite broadcast network: service
//               codes, message id and the flit layout exchanged between a
//               network interface and its router.
// Revision    : 1.0 - initial release
// ============================================================================
package BrLitePkg;

    localparam int BR_ADDR_W    = 16;
    localparam int BR_ID_W      = 4;
    localparam int BR_PAYLOAD_W = 16;

    typedef enum logic [1:0] {
        BR_SVC_ALL   = 2'd0,
        BR_SVC_TGT   = 2'd1,
        BR_SVC_MON   = 2'd2,
        BR_SVC_CLEAR = 2'd3
    } br_svc_t;

    typedef logic [BR_ID_W-1:0] br_id_t;

    typedef struct packed {
        logic [BR_ADDR_W-1:0]    seq_source;
        logic [BR_ADDR_W-1:0]    seq_target;
        br_svc_t                 service;
        br_id_t                  id;
        logic [BR_PAYLOAD_W-1:0] payload;
    } br_data_t;

endpackage : BrLitePkg
`default_nettype wire

// File: rtl/br_lite_ni_fifo.sv
`default_nettype none
// ============================================================================
// Module      : br_lite_fifo
// Description : Count-based circular queue with first-word-fall-through read.
//               A push while full and a pop while empty are ignored.
// Ports       : clk_i/rst_ni  - clock, async active-low reset
//               push_i/data_i - write strobe and data
//               pop_i         - remove head
//               data_o        - current head (valid while !empty_o)
//               full_o/empty_o- occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module br_lite_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int                c_ptr_w    = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]  c_full_cnt = (c_ptr_w + 1)'(DEPTH);

    T                   mem_q [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q;
    logic [c_ptr_w-1:0] rd_ptr_q;
    logic [c_ptr_w:0]   count_q;

    logic w_do_push;
    logic w_do_pop;

    assign full_o    = (count_q == c_full_cnt);
    assign empty_o   = (count_q == '0);
    assign w_do_push = push_i && !full_o;
    assign w_do_pop  = pop_i && !empty_o;
    assign data_o    = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (w_do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule : br_lite_fifo
`default_nettype wire

// File: rtl/br_lite_ni.sv
`default_nettype none
// ============================================================================
// Module      : br_lite_ni
// Description : Network interface between a processing element and the local
//               port of a BR-lite router. Messages from the PE are queued and
//               offered to the router with a four-phase req/ack handshake;
//               flits from the router are accepted with a four-phase
//               handshake into a receive queue read by the PE.
// Ports       : clk_i, rst_ni                 - clock, async active-low reset
//               tx_valid_i/tx_ready_o         - PE message offer / queue room
//               tx_service_i/target/payload   - PE message fields
//               rx_valid_o/rx_ready_i/rx_data_o - receive queue head to PE
//               flit_o/req_o/ack_i/local_busy_i - router local input side
//               flit_i/req_i/ack_o            - router local output side
// Revision    : 1.0 - initial release
// ============================================================================
module br_lite_ni
    import BrLitePkg::*;
#(
    parameter logic [15:0] SEQ_ADDRESS = 16'h0000,
    parameter int          TX_DEPTH    = 4,
    parameter int          RX_DEPTH    = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    tx_valid_i,
    output logic                    tx_ready_o,
    input  br_svc_t                 tx_service_i,
    input  logic [15:0]             tx_target_i,
    input  logic [BR_PAYLOAD_W-1:0] tx_payload_i,
    output logic                    rx_valid_o,
    input  logic                    rx_ready_i,
    output br_data_t                rx_data_o,
    output br_data_t                flit_o,
    output logic                    req_o,
    input  logic                    ack_i,
    input  logic                    local_busy_i,
    input  br_data_t                flit_i,
    input  logic                    req_i,
    output logic                    ack_o
);

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_REQ  = 2'd1;
    localparam logic [1:0] TX_REL  = 2'd2;

    localparam logic RX_IDLE = 1'b0;
    localparam logic RX_ACK  = 1'b1;

    logic [1:0] tx_state_q, tx_state_d;
    logic       rx_state_q, rx_state_d;
    br_id_t     id_cnt_q, id_cnt_d;
    br_data_t   flit_q, flit_d;

    br_data_t   w_tx_in;
    br_data_t   w_tx_head;
    logic       w_tx_full, w_tx_empty;
    logic       w_tx_push, w_tx_pop, w_tx_start;

    logic       w_rx_full, w_rx_empty;
    logic       w_rx_accept, w_rx_push, w_rx_pop;

    // ------------------------------------------------------------------
    // Queues
    // ------------------------------------------------------------------
    always_comb begin
        w_tx_in            = '0;
        w_tx_in.seq_source = SEQ_ADDRESS;
        w_tx_in.seq_target = tx_target_i;
        w_tx_in.service    = tx_service_i;
        w_tx_in.payload    = tx_payload_i;
    end

    // Ready depends only on the registered count, so a pop in the same
    // cycle never lets a push into a full queue.
    assign tx_ready_o = !w_tx_full;
    assign w_tx_push  = tx_valid_i && !w_tx_full;

    br_lite_fifo #(
        .DEPTH (TX_DEPTH),
        .T     (br_data_t)
    ) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_tx_push),
        .data_i  (w_tx_in),
        .pop_i   (w_tx_pop),
        .data_o  (w_tx_head),
        .full_o  (w_tx_full),
        .empty_o (w_tx_empty)
    );

    br_lite_fifo #(
        .DEPTH (RX_DEPTH),
        .T     (br_data_t)
    ) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_rx_push),
        .data_i  (flit_i),
        .pop_i   (w_rx_pop),
        .data_o  (rx_data_o),
        .full_o  (w_rx_full),
        .empty_o (w_rx_empty)
    );

    assign rx_valid_o = !w_rx_empty;
    assign w_rx_pop   = rx_ready_i && !w_rx_empty;

    // ------------------------------------------------------------------
    // TX handshake FSM
    // ------------------------------------------------------------------
    // A lingering ack from the previous transfer must be gone before the
    // next request is raised, otherwise it would be mistaken for consumption.
    assign w_tx_start = (tx_state_q == TX_IDLE) && !w_tx_empty
                        && !local_busy_i && !ack_i;
    // Any ack ends the transfer, whether or not the router kept the flit.
    assign w_tx_pop   = (tx_state_q == TX_REQ) && ack_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_state_q <= TX_IDLE;
            id_cnt_q   <= '0;
            flit_q     <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            id_cnt_q   <= id_cnt_d;
            flit_q     <= flit_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE: if (w_tx_start) tx_state_d = TX_REQ;
            TX_REQ:  if (ack_i)      tx_state_d = TX_REL;
            TX_REL:  if (!ack_i)     tx_state_d = TX_IDLE;
            default:                 tx_state_d = TX_IDLE;
        endcase
    end

    // The flit is captured on entry to TX_REQ and held for the whole
    // handshake; local_busy_i is not consulted once the request is up.
    always_comb begin
        flit_d   = flit_q;
        id_cnt_d = id_cnt_q;
        if (w_tx_start) begin
            flit_d            = w_tx_head;
            flit_d.seq_source = SEQ_ADDRESS;
            flit_d.id         = id_cnt_q;
        end
        if (w_tx_pop) id_cnt_d = id_cnt_q + 1'b1;
    end

    always_comb begin
        req_o  = (tx_state_q == TX_REQ);
        flit_o = flit_q;
    end

    // ------------------------------------------------------------------
    // RX handshake FSM
    // ------------------------------------------------------------------
    // Holding off the ack while full is the backpressure; the router keeps
    // req_i up so nothing is dropped.
    assign w_rx_accept = (rx_state_q == RX_IDLE) && req_i && !w_rx_full;
    assign w_rx_push   = w_rx_accept && (flit_i.service != BR_SVC_CLEAR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rx_state_q <= RX_IDLE;
        else         rx_state_q <= rx_state_d;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE: if (w_rx_accept) rx_state_d = RX_ACK;
            RX_ACK:  if (!req_i)      rx_state_d = RX_IDLE;
            default:                  rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        ack_o = (rx_state_q == RX_ACK);
    end

endmodule : br_lite_ni
`default_nettype wire

// File: tb/tb_br_lite_ni.sv
`default_nettype none
// ============================================================================
// Module      : tb_br_lite_ni
// Description : Self-checking bench for br_lite_ni: directed scenarios with
//               literal expectations plus randomized PE/router traffic, all
//               compared every cycle against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_br_lite_ni;
    import BrLitePkg::*;

    localparam logic [15:0] SEQ = 16'h1234;
    localparam int          TXD = 4;
    localparam int          RXD = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                    tv, ack, busy, rr, reqi;
    br_svc_t                 svc;
    logic [15:0]             tgt;
    logic [BR_PAYLOAD_W-1:0] pl;
    br_data_t                fin;

    logic     tx_ready, rx_valid, req_o, ack_o;
    br_data_t rx_data, flit_o;

    br_lite_ni #(
        .SEQ_ADDRESS (SEQ),
        .TX_DEPTH    (TXD),
        .RX_DEPTH    (RXD)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .tx_valid_i   (tv),
        .tx_ready_o   (tx_ready),
        .tx_service_i (svc),
        .tx_target_i  (tgt),
        .tx_payload_i (pl),
        .rx_valid_o   (rx_valid),
        .rx_ready_i   (rr),
        .rx_data_o    (rx_data),
        .flit_o       (flit_o),
        .req_o        (req_o),
        .ack_i        (ack),
        .local_busy_i (busy),
        .flit_i       (fin),
        .req_i        (reqi),
        .ack_o        (ack_o)
    );

    // ---------------- reference model ----------------
    br_data_t txq[$];
    br_data_t rxq[$];
    int       tx_phase;      // 0 waiting, 1 offering, 2 waiting for ack release
    br_id_t   next_id;
    br_data_t flit_m;
    bit       rx_acking;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        tx_phase  = 0;
        next_id   = '0;
        flit_m    = '0;
        rx_acking = 0;
    endtask

    task automatic model_update();
        int       txn, rxn;
        br_data_t m;
        bit       accept;
        txn = txq.size();
        rxn = rxq.size();
        // TX: the PE message as the router should eventually see it
        m            = '0;
        m.seq_target = tgt;
        m.service    = svc;
        m.payload    = pl;
        if (tx_phase == 0) begin
            if (txn > 0 && !busy && !ack) begin
                flit_m            = txq[0];
                flit_m.seq_source = SEQ;
                flit_m.id         = next_id;
                tx_phase          = 1;
            end
        end else if (tx_phase == 1) begin
            if (ack) begin
                void'(txq.pop_front());
                next_id  = next_id + 1'b1;
                tx_phase = 2;
            end
        end else if (!ack) begin
            tx_phase = 0;
        end
        if (tv && txn < TXD) txq.push_back(m);
        // RX
        accept = !rx_acking && reqi && (rxn < RXD);
        if (rr && rxn > 0) void'(rxq.pop_front());
        if (accept) begin
            rx_acking = 1;
            if (fin.service != BR_SVC_CLEAR) rxq.push_back(fin);
        end else if (rx_acking && !reqi) begin
            rx_acking = 0;
        end
    endtask

    task automatic compare();
        chk("req_o", req_o, tx_phase == 1);
        chk("flit_o", flit_o, flit_m);
        chk("tx_ready_o", tx_ready, txq.size() < TXD);
        chk("ack_o", ack_o, rx_acking);
        chk("rx_valid_o", rx_valid, rxq.size() > 0);
        if (rxq.size() > 0) chk("rx_data_o", rx_data, rxq[0]);
    endtask

    // Advance one clock: model follows the posedge, outputs checked at negedge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic idle_inputs();
        tv = 0; ack = 0; busy = 0; rr = 0; reqi = 0;
        fin = '0; svc = BR_SVC_ALL; tgt = '0; pl = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        step();
    endtask

    function automatic br_data_t rnd_flit(input br_svc_t s);
        br_data_t f;
        f.seq_source = 16'($urandom);
        f.seq_target = 16'($urandom);
        f.service    = s;
        f.id         = br_id_t'($urandom);
        f.payload    = BR_PAYLOAD_W'($urandom);
        return f;
    endfunction

    task automatic set_msg(input br_svc_t s, input logic [15:0] t, input logic [BR_PAYLOAD_W-1:0] p);
        tv = 1; svc = s; tgt = t; pl = p;
    endtask

    task automatic wait_req();
        for (int k = 0; k < 12 && !req_o; k++) step();
        chk("req_o_timeout", req_o, 1'b1);
    endtask

    initial begin
        bit pulse;
        int rr_bias;
        model_reset();
        idle_inputs();
        pulse = 0;

        // ---------------- reset values ----------------
        rst_n = 0;
        step();
        chk("rst_req", req_o, 1'b0);
        chk("rst_ack", ack_o, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_flit", flit_o, 64'h0);
        step();
        rst_n = 1;
        step();

        // ---------------- single message, slow router ----------------
        set_msg(BR_SVC_TGT, 16'd5, 16'h000A);
        step();
        tv = 0;
        step();
        chk("t1_req", req_o, 1'b1);
        chk("t1_id", flit_o.id, 4'd0);
        chk("t1_src", flit_o.seq_source, 16'h1234);
        chk("t1_tgt", flit_o.seq_target, 16'd5);
        chk("t1_svc", flit_o.service, BR_SVC_TGT);
        chk("t1_pl", flit_o.payload, 16'h000A);
        step();
        step();
        ack = 1;
        step();
        chk("t1_req_fall", req_o, 1'b0);
        ack = 0;
        step();

        // ---------------- single-cycle ack pulse, back to back ----------------
        set_msg(BR_SVC_ALL, 16'd6, 16'h000B);
        step();
        set_msg(BR_SVC_MON, 16'd7, 16'h000C);
        step();
        tv = 0;
        chk("t2_req", req_o, 1'b1);
        chk("t2_id", flit_o.id, 4'd1);
        chk("t2_pl", flit_o.payload, 16'h000B);
        ack = 1;
        step();
        ack = 0;
        step();
        chk("t2_idle", req_o, 1'b0);
        step();
        chk("t2_next_req", req_o, 1'b1);
        chk("t2_next_id", flit_o.id, 4'd2);
        chk("t2_next_pl", flit_o.payload, 16'h000C);
        ack = 1;
        step();
        ack = 0;
        step();

        // ---------------- local_busy holds off requests ----------------
        do_reset();
        busy = 1;
        for (int i = 0; i < 3; i++) begin
            set_msg(BR_SVC_ALL, 16'd9, 16'(16'h0100 + i));
            step();
        end
        tv = 0;
        step();
        step();
        chk("busy_no_req", req_o, 1'b0);
        chk("busy_full_ready", tx_ready, 1'b1);
        busy = 0;
        for (int i = 0; i < 3; i++) begin
            wait_req();
            chk("busy_order_id", flit_o.id, 4'(i));
            chk("busy_order_pl", flit_o.payload, 16'(16'h0100 + i));
            ack = 1;
            step();
            ack = 0;
            step();
        end

        // ---------------- RX backpressure ----------------
        do_reset();
        for (int i = 0; i < 5; i++) begin
            reqi = 1;
            fin  = rnd_flit(BR_SVC_TGT);
            for (int k = 0; k < 6 && !ack_o; k++) step();
            if (i < 4) begin
                chk("rx_acked", ack_o, 1'b1);
                reqi = 0;
                step();
            end else begin
                chk("rx_backpressure", ack_o, 1'b0);
                chk("rx_full_valid", rx_valid, 1'b1);
            end
        end
        rr = 1;
        step();
        rr = 0;
        step();
        chk("rx_ack_after_pop", ack_o, 1'b1);
        reqi = 0;
        rr = 1;
        for (int i = 0; i < 5; i++) step();
        rr = 0;
        chk("rx_drained", rx_valid, 1'b0);

        // ---------------- CLEAR flits are acked but not stored ----------------
        reqi = 1;
        fin  = rnd_flit(BR_SVC_CLEAR);
        step();
        chk("clr_ack", ack_o, 1'b1);
        chk("clr_no_valid", rx_valid, 1'b0);
        reqi = 0;
        step();
        chk("clr_still_empty", rx_valid, 1'b0);

        // ---------------- asynchronous reset mid-handshake ----------------
        set_msg(BR_SVC_TGT, 16'd3, 16'h0033);
        step();
        tv = 0;
        wait_req();
        reqi = 1;
        fin  = rnd_flit(BR_SVC_ALL);
        for (int k = 0; k < 4 && !ack_o; k++) step();
        chk("pre_rst_ack", ack_o, 1'b1);
        chk("pre_rst_req", req_o, 1'b1);
        #2;
        rst_n = 0;
        #1;
        chk("async_rst_req", req_o, 1'b0);
        chk("async_rst_ack", ack_o, 1'b0);
        idle_inputs();
        step();
        rst_n = 1;
        step();
        chk("post_rst_ready", tx_ready, 1'b1);
        chk("post_rst_valid", rx_valid, 1'b0);

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 3000; c++) begin
            rr_bias = (c < 1500) ? 1 : 3;
            // router consuming the NI's requests
            if (ack) begin
                if (pulse || !req_o) ack = 0;
            end else if (req_o && $urandom_range(0, 2) == 0) begin
                ack   = 1;
                pulse = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 15) == 0) busy = ~busy;
            // PE offering messages
            tv  = ($urandom_range(0, 1) == 1);
            svc = br_svc_t'($urandom_range(0, 2));
            tgt = 16'($urandom);
            pl  = BR_PAYLOAD_W'($urandom);
            rr  = ($urandom_range(0, 3) < rr_bias);
            // router delivering flits, holding req until acked
            if (reqi) begin
                if (ack_o) reqi = 0;
            end else if (!ack_o && $urandom_range(0, 1) == 1) begin
                reqi = 1;
                fin  = rnd_flit(br_svc_t'($urandom_range(0, 3)));
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_br_lite_ni
`default_nettype wire
